// File: rtl/mux4to1_pkg.sv
// Shared types, limits and the lane-select helper for the mux4to1 selector family.
package mux_pkg;

   localparam int DEFAULT_NUM_INPUTS = 4;
   localparam int MAX_LANES          = 16;
   localparam int MAX_DATA_W         = 32;
   localparam int MAX_SEL_W          = $clog2(MAX_LANES);
   localparam int MAX_E_W            = MAX_LANES * MAX_DATA_W;
   localparam int E_IDX_W            = $clog2(MAX_E_W);

   typedef logic [1:0] sel4_t;

   // Callers widen e/s to the maximum sizes and truncate the result back to their lane width.
   // An out-of-range select (or an unknown one) matches no lane and yields zero.
   function automatic logic [MAX_DATA_W-1:0] lane_sel(
      input logic [MAX_E_W-1:0]   e,
      input logic [MAX_SEL_W-1:0] s,
      input int                   num_inputs,
      input int                   data_w
   );
      logic [MAX_DATA_W-1:0] r;
      logic [E_IDX_W-1:0]    idx;
      r = '0;
      for (int k = 0; k < MAX_LANES; k++) begin
         if (k < num_inputs && s == MAX_SEL_W'(k)) begin
            for (int b = 0; b < MAX_DATA_W; b++) begin
               if (b < data_w) begin
                  idx  = E_IDX_W'(k * data_w + b);
                  r[b] = e[idx];
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux4to1_if.sv
// Bus bundle for mux4to1: select, packed lanes, valid and both output copies.
// sel_err is present only when MUX_SEL_ERR_EN is defined.
interface mux4to1_if
   import mux_pkg::*;
#(
   parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
   parameter int DATA_W     = 1
);
   localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic [SEL_W-1:0]             s;
   logic [NUM_INPUTS*DATA_W-1:0] e;
   logic                         in_valid;
   logic [DATA_W-1:0]            y;
   logic [DATA_W-1:0]            y_q;
   logic                         out_valid;
`ifdef MUX_SEL_ERR_EN
   logic                         sel_err;
`endif

   modport master (
      output s, e, in_valid,
      input  y, y_q, out_valid
`ifdef MUX_SEL_ERR_EN
      , input sel_err
`endif
   );

   modport slave (
      input  s, e, in_valid,
      output y, y_q, out_valid
`ifdef MUX_SEL_ERR_EN
      , output sel_err
`endif
   );

endinterface

// File: rtl/mux4to1_out_reg.sv
// Registered copy of the selected lane with valid tracking and async active-low reset.
// Optional sel_err flop under MUX_SEL_ERR_EN.
module mux_out_reg #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] d_p0,
   output logic [DATA_W-1:0] y_q,
   output logic              out_valid
`ifdef MUX_SEL_ERR_EN
   ,
   input  logic              oor_p0,
   output logic              sel_err
`endif
);

   logic [DATA_W-1:0] y_p1;
   logic              vld_p1;

   // p0 -> p1: data holds across invalid cycles, valid does not
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_p1   <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) y_p1 <= d_p0;
      end
   end

   assign y_q       = y_p1;
   assign out_valid = vld_p1;

`ifdef MUX_SEL_ERR_EN
   logic sel_err_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sel_err_p1 <= 1'b0;
      else        sel_err_p1 <= oor_p0 && in_valid;
   end

   assign sel_err = sel_err_p1;
`endif

endmodule

// File: rtl/mux4to1.sv
// Parameterised N:1 selector: combinational y plus a one-cycle registered copy.
// Define MUX_SEL_ERR_EN for the registered out-of-range flag and its simulation check.
module mux4to1
   import mux_pkg::*;
#(
   parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
   parameter int DATA_W     = 1
) (
   input logic       clk,
   input logic       rst_n,
   mux4to1_if.slave  bus
);
   localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("mux4to1: NUM_INPUTS must be >= 2");
   end
   if (DATA_W < 1) begin : g_bad_data_w
      $error("mux4to1: DATA_W must be >= 1");
   end
   if (NUM_INPUTS > MAX_LANES || DATA_W > MAX_DATA_W) begin : g_too_big
      $error("mux4to1: NUM_INPUTS/DATA_W exceed mux_pkg limits");
   end
   if ($bits(bus.e) != NUM_INPUTS * DATA_W) begin : g_bad_e_w
      $error("mux4to1: e width must equal NUM_INPUTS*DATA_W");
   end
   if ($bits(bus.y) != DATA_W || $bits(bus.s) != SEL_W) begin : g_bad_bus_w
      $error("mux4to1: interface parameters do not match the module");
   end

   logic [DATA_W-1:0] y_p0;

   // p0: purely combinational lane select, independent of clk/rst_n/in_valid
   assign y_p0  = DATA_W'(lane_sel(MAX_E_W'(bus.e), MAX_SEL_W'(bus.s), NUM_INPUTS, DATA_W));
   assign bus.y = y_p0;

`ifdef MUX_SEL_ERR_EN
   logic sel_oor;

   assign sel_oor = ({1'b0, bus.s} >= (SEL_W + 1)'(NUM_INPUTS));

   always_comb begin
      assert (sel_oor !== 1'b1)
         else $warning("mux4to1: select %0d out of range", bus.s);
   end
`endif

   mux_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .d_p0      (y_p0),
      .y_q       (bus.y_q),
      .out_valid (bus.out_valid)
`ifdef MUX_SEL_ERR_EN
      ,
      .oor_p0    (sel_oor),
      .sel_err   (bus.sel_err)
`endif
   );

endmodule

// File: tb/tb_mux4to1.sv
// Self-checking bench for mux4to1: lane tables, 8:1 composition, registered path,
// async reset, non-power-of-2 and wide-lane configurations.
module tb_mux4to1;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic run_clk = 1'b0;
   int   errs = 0;
   int   checks = 0;

   always begin
      #5;
      if (run_clk) clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   mux4to1_if #(.NUM_INPUTS(4), .DATA_W(1)) if4 ();
   mux4to1_if #(.NUM_INPUTS(4), .DATA_W(1)) ifa ();
   mux4to1_if #(.NUM_INPUTS(4), .DATA_W(1)) ifb ();
   mux4to1_if #(.NUM_INPUTS(3), .DATA_W(4)) if3 ();
   mux4to1_if #(.NUM_INPUTS(4), .DATA_W(8)) if8 ();

   mux4to1 #(.NUM_INPUTS(4), .DATA_W(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(if4));
   mux4to1 #(.NUM_INPUTS(4), .DATA_W(1)) u_lo  (.clk(clk), .rst_n(rst_n), .bus(ifa));
   mux4to1 #(.NUM_INPUTS(4), .DATA_W(1)) u_hi  (.clk(clk), .rst_n(rst_n), .bus(ifb));
   mux4to1 #(.NUM_INPUTS(3), .DATA_W(4)) u_n3  (.clk(clk), .rst_n(rst_n), .bus(if3));
   mux4to1 #(.NUM_INPUTS(4), .DATA_W(8)) u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));

   // 8:1 built from two leaf cells and a final 2:1 on the top select bit
   logic [2:0] s8;
   logic       y8;
   assign y8 = s8[2] ? ifb.y : ifa.y;

   typedef struct {
      logic [3:0] e;
      sel4_t      s;
      logic       y;
   } vec_t;

   vec_t tbl [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: treat e as an array of w-bit lanes and index it; beyond the last lane read zero.
   function automatic logic [31:0] ref_mux(input int n, input int w, input logic [63:0] e, input int s);
      if (s >= n) return '0;
      return 32'((e >> (s * w)) & ((64'd1 << w) - 64'd1));
   endfunction

   task automatic apply8(input logic [2:0] s, input logic [7:0] e);
      s8    = s;
      ifa.s = s[1:0];
      ifb.s = s[1:0];
      ifa.e = e[3:0];
      ifb.e = e[7:4];
      #1;
   endtask

   logic [31:0] exp4_q, exp8_q;
   logic        exp4_v, exp8_v;

   initial begin
      rst_n = 1'b0;
      s8 = '0;
      if4.s = '0; if4.e = '0; if4.in_valid = 1'b0;
      ifa.s = '0; ifa.e = '0; ifa.in_valid = 1'b0;
      ifb.s = '0; ifb.e = '0; ifb.in_valid = 1'b0;
      if3.s = '0; if3.e = '0; if3.in_valid = 1'b0;
      if8.s = '0; if8.e = '0; if8.in_valid = 1'b0;
      #1;
      check("reset y_q",          32'(if4.y_q),       32'd0);
      check("reset out_valid",    32'(if4.out_valid), 32'd0);
      check("reset y_q w8",       32'(if8.y_q),       32'd0);
      check("reset out_valid n3", 32'(if3.out_valid), 32'd0);
`ifdef MUX_SEL_ERR_EN
      check("reset sel_err n3",   32'(if3.sel_err),   32'd0);
`endif
      #2 rst_n = 1'b1;

      // Combinational leaf cell with the clock idle
      tbl[0] = '{e: 4'b0100, s: 2'd2, y: 1'b1};
      tbl[1] = '{e: 4'b0111, s: 2'd3, y: 1'b0};
      tbl[2] = '{e: 4'b1000, s: 2'd3, y: 1'b1};
      tbl[3] = '{e: 4'b0001, s: 2'd0, y: 1'b1};
      for (int i = 0; i < 4; i++) begin
         if4.e = tbl[i].e;
         if4.s = tbl[i].s;
         #1;
         check($sformatf("table[%0d] y", i), 32'(if4.y), 32'(tbl[i].y));
      end
      for (int ev = 0; ev < 16; ev++) begin
         for (int sv = 0; sv < 4; sv++) begin
            if4.e = 4'(ev);
            if4.s = 2'(sv);
            #1;
            check($sformatf("comb4 e=%0h s=%0d", ev, sv), 32'(if4.y), ref_mux(4, 1, 64'(ev), sv));
         end
      end

      // 8:1 composition
      apply8(3'd5, 8'h20);
      check("mux8 s=5 e=20", 32'(y8), 32'd1);
      apply8(3'd5, 8'hDF);
      check("mux8 s=5 e=DF", 32'(y8), 32'd0);
      for (int i = 0; i < 10; i++) begin
         logic [2:0] rs;
         logic [7:0] re;
         rs = 3'($urandom_range(0, 7));
         re = 8'($urandom);
         apply8(rs, re);
         check($sformatf("mux8 rand s=%0d e=%0h", rs, re), 32'(y8), ref_mux(8, 1, 64'(re), int'(rs)));
      end

      // Registered path on the default leaf cell
      run_clk = 1'b1;
      @(posedge clk); #1;
      if4.in_valid = 1'b1; if4.s = 2'd1; if4.e = 4'b0010;
      @(posedge clk); #1;
      check("reg capture y_q",       32'(if4.y_q),       32'd1);
      check("reg capture out_valid", 32'(if4.out_valid), 32'd1);
      if4.in_valid = 1'b0; if4.e = 4'b0000;
      @(posedge clk); #1;
      check("reg hold y_q",          32'(if4.y_q),       32'd1);
      check("reg hold out_valid",    32'(if4.out_valid), 32'd0);
      if4.in_valid = 1'b1; if4.s = 2'd3; if4.e = 4'b1000;
      @(posedge clk); #1;
      check("reg recapture out_valid", 32'(if4.out_valid), 32'd1);
      // Asynchronous reset between edges with a capture pending
      if4.s = 2'd0; if4.e = 4'b0000;
      #2 rst_n = 1'b0;
      #1;
      check("async rst y_q",       32'(if4.y_q),       32'd0);
      check("async rst out_valid", 32'(if4.out_valid), 32'd0);
      if4.s = 2'd2; if4.e = 4'b0100;
      #1;
      check("y tracks in reset", 32'(if4.y), 32'd1);
      @(posedge clk); #1;
      check("edge in reset y_q",       32'(if4.y_q),       32'd0);
      check("edge in reset out_valid", 32'(if4.out_valid), 32'd0);
      rst_n = 1'b1;
      if4.s = 2'd3; if4.e = 4'b1000;
      @(posedge clk); #1;
      check("post-reset y_q",       32'(if4.y_q),       32'd1);
      check("post-reset out_valid", 32'(if4.out_valid), 32'd1);
      if4.in_valid = 1'b0;

      // Wide lanes
      if8.e = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      if8.s = 2'd2;
      #1;
      check("w8 comb y", 32'(if8.y), 32'hCC);
      if8.in_valid = 1'b1;
      @(posedge clk); #1;
      check("w8 y_q",       32'(if8.y_q),       32'hCC);
      check("w8 out_valid", 32'(if8.out_valid), 32'd1);

      // Non-power-of-2 lane count
      if3.s = 2'd3; if3.e = 12'hFFF;
      #1;
      check("n3 oor y", 32'(if3.y), 32'h0);
      if3.in_valid = 1'b1;
      @(posedge clk); #1;
      check("n3 oor y_q", 32'(if3.y_q), 32'h0);
`ifdef MUX_SEL_ERR_EN
      check("n3 sel_err set", 32'(if3.sel_err), 32'd1);
`endif
      if3.s = 2'd2; if3.e = 12'hA53;
      #1;
      check("n3 s=2 y", 32'(if3.y), 32'hA);
      @(posedge clk); #1;
      check("n3 s=2 y_q", 32'(if3.y_q), 32'hA);
`ifdef MUX_SEL_ERR_EN
      check("n3 sel_err clear", 32'(if3.sel_err), 32'd0);
`endif
      if3.in_valid = 1'b0; if3.s = 2'd3;
      @(posedge clk); #1;
      check("n3 idle out_valid", 32'(if3.out_valid), 32'd0);
      check("n3 idle y_q hold",  32'(if3.y_q),       32'hA);
`ifdef MUX_SEL_ERR_EN
      check("n3 idle sel_err",   32'(if3.sel_err),   32'd0);
`endif
      if3.s = 2'd0;

      // Randomised registered traffic on two configurations
      exp4_q = 32'd1;  exp4_v = 1'b0;
      exp8_q = 32'hCC; exp8_v = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if4.in_valid = 1'($urandom_range(0, 1));
         if4.s        = 2'($urandom_range(0, 3));
         if4.e        = 4'($urandom);
         if8.in_valid = 1'($urandom_range(0, 1));
         if8.s        = 2'($urandom_range(0, 3));
         if8.e        = 32'($urandom);
         #1;
         check("rand4 comb y", 32'(if4.y), ref_mux(4, 1, 64'(if4.e), int'(if4.s)));
         check("rand8 comb y", 32'(if8.y), ref_mux(4, 8, 64'(if8.e), int'(if8.s)));
         if (if4.in_valid) exp4_q = ref_mux(4, 1, 64'(if4.e), int'(if4.s));
         exp4_v = if4.in_valid;
         if (if8.in_valid) exp8_q = ref_mux(4, 8, 64'(if8.e), int'(if8.s));
         exp8_v = if8.in_valid;
         @(posedge clk); #1;
         check("rand4 y_q",       32'(if4.y_q),       exp4_q);
         check("rand4 out_valid", 32'(if4.out_valid), 32'(exp4_v));
         check("rand8 y_q",       32'(if8.y_q),       exp8_q);
         check("rand8 out_valid", 32'(if8.out_valid), 32'(exp8_v));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
